// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit with alignment checks and sub-word RMW
module load_store_unit #(
  parameter int DEPTH_WORDS = 512
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] rdata_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_LOAD,
    S_RMW,
    S_WRITE
  } state_e;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, load_d;
  logic        resp_valid_q;
  logic        resp_err_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ready_o = (state_q == S_IDLE) && rst_ni;
  assign accept  = req_i && ready_o;

  assign req_err = (size_i == 2'b11)
                || ((size_i == SZ_HALF) && addr_i[0])
                || ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00))
                || ({2'b00, addr_i[31:2]} >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                state_d = S_ERR;
          else if (!we_i)             state_d = S_LOAD;
          else if (size_i == SZ_WORD) state_d = S_WRITE;
          else                        state_d = S_RMW;
        end
      end
      S_RMW:   state_d = S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane extraction from the latched address; little-endian byte numbering.
  always_comb begin
    ld_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      SZ_BYTE: load_d = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_d = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_d = mem_rdata_i;
    endcase
  end

  always_comb begin
    merge_d = mem_rdata_i;
    if (size_q == SZ_BYTE) begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merge_d[31:16] = wdata_q[15:0];
    end else begin
      merge_d[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      merge_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= (state_q == S_ERR) || (state_q == S_LOAD) || (state_q == S_WRITE);
      resp_err_q   <= (state_q == S_ERR);
      if (accept) begin
        addr_q  <= addr_i;
        size_q  <= size_i;
        we_q    <= we_i;
        uns_q   <= unsigned_i;
        wdata_q <= wdata_i;
      end
      if (state_q == S_LOAD) rdata_q <= load_d;
      if (state_q == S_RMW)  merge_q <= merge_d;
    end
  end

  // Write enable comes only from the state register so reset kills it at once.
  assign mem_wen_o    = (state_q == S_WRITE) && we_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wdata_o  = (size_q == SZ_WORD) ? wdata_q : merge_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign rdata_o      = rdata_q;

endmodule
